// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan readback monitor.
// Patterns are active-low, ordered a..g from bit 6 down to bit 0.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] NIB_BLANK = 4'hE;
   localparam logic [3:0] NIB_ERR   = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HOLD  = 2'd2
   } seg_state_e;

endpackage

// File: rtl/seg_scan_readback_if.sv
// Display bus seen by the readback monitor: segment/anode lines in, decoded readback out.
// The master drives the display lines; the slave is the monitor.
interface seg_scan_readback_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg_n;
   logic [NUM_DIGITS-1:0]   an_n;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   digit_vld;
   logic                    frame_done;
   logic                    err;

   modport master (
      output seg_n, an_n,
      input  digits, digit_vld, frame_done, err
   );

   modport slave (
      input  seg_n, an_n,
      output digits, digit_vld, frame_done, err
   );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern to BCD decoder; blank is legal, anything
// outside the ten digits and blank yields NIB_ERR and raises illegal.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       illegal
);

   // pattern lookup
   always_comb begin
      nibble  = NIB_ERR;
      illegal = 1'b0;
      case (pattern)
         SEG_0:     nibble = 4'd0;
         SEG_1:     nibble = 4'd1;
         SEG_2:     nibble = 4'd2;
         SEG_3:     nibble = 4'd3;
         SEG_4:     nibble = 4'd4;
         SEG_5:     nibble = 4'd5;
         SEG_6:     nibble = 4'd6;
         SEG_7:     nibble = 4'd7;
         SEG_8:     nibble = 4'd8;
         SEG_9:     nibble = 4'd9;
         SEG_BLANK: nibble = NIB_BLANK;
         default: begin
            nibble  = NIB_ERR;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg_scan_readback.sv
// Passive monitor of the multiplexed 7-segment bus: waits for each digit strobe
// to be stable, decodes it back to BCD and reports per-frame completion.
module seg_scan_readback
   import seg_pkg::*;
#(
   parameter  int NUM_DIGITS    = 4,
   parameter  int STABLE_CYCLES = 4,
   localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   seg_scan_readback_if.slave bus
);

   localparam bit ONE_SHOT = (STABLE_CYCLES == 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);

   logic [6:0]              seg_r;
   logic [NUM_DIGITS-1:0]   an_r;
   logic [6:0]              ref_seg_r;
   logic [NUM_DIGITS-1:0]   ref_an_r;
   seg_state_e              state_r;
   logic [CNT_W-1:0]        cnt_r;
   logic [4*NUM_DIGITS-1:0] digits_r;
   logic [NUM_DIGITS-1:0]   vld_r;
   logic                    frame_r;
   logic                    err_r;

   logic                    onehot_s;
   logic                    same_s;
   logic                    start_s;
   logic                    accept_s;
   logic                    load_s;
   seg_state_e              state_nx_s;
   logic [CNT_W-1:0]        cnt_nx_s;
   logic [NUM_DIGITS-1:0]   vld_nx_s;
   logic [3:0]              nibble_s;
   logic                    illegal_s;

   // While matching, seg_r equals ref_seg_r, so the live sample can feed the decoder.
   seg_pattern_decode u_decode (
      .pattern (seg_r),
      .nibble  (nibble_s),
      .illegal (illegal_s)
   );

   assign onehot_s = $onehot(~an_r);
   assign same_s   = (an_r == ref_an_r) && (seg_r == ref_seg_r);
   assign start_s  = onehot_s && ((state_r == IDLE) || !same_s);

   // stability FSM next-state and counter
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      load_s     = 1'b0;
      accept_s   = 1'b0;
      if (start_s) begin
         load_s   = 1'b1;
         cnt_nx_s = CNT_ONE;
         if (ONE_SHOT) begin
            accept_s   = 1'b1;
            state_nx_s = HOLD;
         end else begin
            state_nx_s = TRACK;
         end
      end else if ((state_r == TRACK) && same_s) begin
         if (cnt_r == CNT_LAST) begin
            accept_s   = 1'b1;
            cnt_nx_s   = CNT_FULL;
            state_nx_s = HOLD;
         end else begin
            cnt_nx_s = cnt_r + CNT_ONE;
         end
      end else if ((state_r == HOLD) && same_s) begin
         state_nx_s = HOLD;
      end else begin
         state_nx_s = IDLE;
         cnt_nx_s   = {CNT_W{1'b0}};
      end
   end

   // A completed frame clears the mask one cycle later; a same-cycle accept still lands.
   always_comb begin
      vld_nx_s = frame_r ? {NUM_DIGITS{1'b0}} : vld_r;
      if (accept_s) begin
         vld_nx_s = vld_nx_s | ~an_r;
      end else begin
         vld_nx_s = vld_nx_s;
      end
   end

   // input sampling, FSM state and capture registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_r     <= SEG_BLANK;
         an_r      <= {NUM_DIGITS{1'b1}};
         ref_seg_r <= SEG_BLANK;
         ref_an_r  <= {NUM_DIGITS{1'b1}};
         state_r   <= IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         digits_r  <= {NUM_DIGITS{NIB_BLANK}};
         vld_r     <= {NUM_DIGITS{1'b0}};
         frame_r   <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         seg_r   <= bus.seg_n;
         an_r    <= bus.an_n;
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         if (load_s) begin
            ref_seg_r <= seg_r;
            ref_an_r  <= an_r;
         end
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (accept_s && !an_r[i]) begin
               digits_r[4*i +: 4] <= nibble_s;
            end
         end
         vld_r   <= vld_nx_s;
         frame_r <= accept_s && (&vld_nx_s);
         err_r   <= accept_s && illegal_s;
      end
   end

   assign bus.digits     = digits_r;
   assign bus.digit_vld  = vld_r;
   assign bus.frame_done = frame_r;
   assign bus.err        = err_r;

endmodule

// File: tb/tb_seg_scan_readback.sv
// Randomized and directed bench for seg_scan_readback against a run-length
// reference model of the display bus.
module tb_seg_scan_readback;

   localparam int ND = 4;
   localparam int SC = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   seg_scan_readback_if #(.NUM_DIGITS(ND)) bus ();

   seg_scan_readback #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference decode table: index = digit value
   logic [6:0] pat_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   // Model state: length of the current run of identical, single-strobe samples
   int             run_len;
   logic [ND-1:0]  run_an;
   logic [6:0]     run_seg;
   logic [ND-1:0]  prev_an;
   logic [6:0]     prev_seg;
   logic [3:0]     m_dig [ND];
   logic [ND-1:0]  m_vld;
   logic           m_frame;
   logic           m_err;
   logic           m_clear;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] ref_decode(input logic [6:0] p);
      if (p == 7'b1111111) return 4'hE;
      for (int d = 0; d < 10; d++) if (pat_tab[d] == p) return 4'(d);
      return 4'hF;
   endfunction

   function automatic logic [15:0] m_digits();
      logic [15:0] v;
      for (int i = 0; i < ND; i++) v[4*i +: 4] = m_dig[i];
      return v;
   endfunction

   task automatic model_reset();
      run_len  = 0;
      run_an   = '1;
      run_seg  = 7'h7F;
      prev_an  = '1;
      prev_seg = 7'h7F;
      for (int i = 0; i < ND; i++) m_dig[i] = 4'hE;
      m_vld   = '0;
      m_frame = 1'b0;
      m_err   = 1'b0;
      m_clear = 1'b0;
   endtask

   // One registered sample reaching the decision logic
   task automatic model_sample(input logic [ND-1:0] an, input logic [6:0] seg);
      logic [3:0] nib;
      m_frame = 1'b0;
      m_err   = 1'b0;
      if (m_clear) m_vld = '0;
      m_clear = 1'b0;
      if ($countones(~an) == 1) begin
         if (run_len > 0 && an == run_an && seg == run_seg) run_len++;
         else begin
            run_len = 1;
            run_an  = an;
            run_seg = seg;
         end
      end else begin
         run_len = 0;
      end
      if (run_len == SC) begin
         nib = ref_decode(seg);
         for (int i = 0; i < ND; i++) begin
            if (!an[i]) begin
               m_dig[i] = nib;
               m_vld[i] = 1'b1;
            end
         end
         m_err = (nib == 4'hF);
         if (&m_vld) begin
            m_frame = 1'b1;
            m_clear = 1'b1;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".digits"}, 32'(bus.digits), 32'(m_digits()));
      check({tag, ".vld"},    32'(bus.digit_vld), 32'(m_vld));
      check({tag, ".frame"},  32'(bus.frame_done), 32'(m_frame));
      check({tag, ".err"},    32'(bus.err), 32'(m_err));
   endtask

   // Drive one cycle of bus values; outputs then reflect the previous cycle's sample
   task automatic step(input logic [ND-1:0] an, input logic [6:0] seg, input string tag);
      bus.an_n  = an;
      bus.seg_n = seg;
      @(posedge clk);
      #1;
      model_sample(prev_an, prev_seg);
      prev_an  = an;
      prev_seg = seg;
      check_outputs(tag);
   endtask

   task automatic hold(input logic [ND-1:0] an, input logic [6:0] seg, input int n, input string tag);
      for (int k = 0; k < n; k++) step(an, seg, tag);
   endtask

   // Asynchronous reset raised between clock edges, released one edge later
   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check({tag, ".rst_digits"}, 32'(bus.digits), 32'hEEEE);
      check({tag, ".rst_vld"},    32'(bus.digit_vld), 32'h0);
      check({tag, ".rst_frame"},  32'(bus.frame_done), 32'h0);
      check({tag, ".rst_err"},    32'(bus.err), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [ND-1:0] sel(input int pos);
      logic [ND-1:0] v = '1;
      v[pos] = 1'b0;
      return v;
   endfunction

   initial begin
      logic [ND-1:0] an;
      logic [6:0]    seg;
      int            guard;

      bus.an_n  = '1;
      bus.seg_n = 7'h7F;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      hold('1, 7'h7F, 4, "idle");

      for (int p = 0; p < ND; p++) hold(sel(p), pat_tab[p+1], 6, "scan");
      hold('1, 7'h7F, 2, "scan_tail");
      check("scan_result", 32'(bus.digits), 32'h4321);

      hold(sel(0), pat_tab[0], 3, "glitch0");
      hold(sel(0), pat_tab[1], 4, "glitch1");
      hold('1, 7'h7F, 2, "glitch_tail");
      check("glitch_vld", 32'(bus.digit_vld), 32'h1);

      hold(4'b1100, pat_tab[8], 10, "two_low");

      hold(sel(2), 7'b1111110, 4, "illegal");
      hold('1, 7'h7F, 2, "illegal_tail");
      check("illegal_nib", 32'(bus.digits[11:8]), 32'hF);

      hold(sel(1), pat_tab[7], 2, "mid_track");
      pulse_reset("rst_track");
      hold(sel(1), pat_tab[7], 4, "post_rst");
      check("post_rst_noacc", 32'(bus.digit_vld), 32'h0);
      hold(sel(1), pat_tab[7], 2, "post_rst_acc");
      check("post_rst_acc_vld", 32'(bus.digit_vld), 32'h2);

      for (int p = 0; p < ND - 1; p++) hold(sel(p), pat_tab[p+5], 6, "prefr");
      guard = 0;
      do begin
         step(sel(ND-1), pat_tab[9], "fr");
         guard++;
      end while (!m_frame && guard < 12);
      check("frame_seen", 32'(bus.frame_done), 32'h1);
      pulse_reset("rst_frame");

      for (int s = 0; s < 150; s++) begin
         case ($urandom_range(0, 9))
            0:       an = '1;
            1:       an = sel($urandom_range(0, ND-1)) & sel($urandom_range(0, ND-1));
            default: an = sel($urandom_range(0, ND-1));
         endcase
         case ($urandom_range(0, 19))
            0:       seg = 7'h7F;
            1, 2:    seg = 7'($urandom);
            default: seg = pat_tab[$urandom_range(0, 9)];
         endcase
         hold(an, seg, $urandom_range(1, 7), "rand");
         if ($urandom_range(0, 49) == 0) pulse_reset("rand_rst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
